// File: rtl/ifetch_sram_responder_if.sv
// Fetch-side request/response bundle for the instruction SRAM responder.
//   req_valid/req_ready/req_addr : byte-addressed 32-bit fetch request
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_err             : instruction word and access-fault flag
// master = fetch unit, slave = responder.
interface ifetch_sram_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ifetch_sram_responder.sv
// Instruction-memory responder: one fetch in flight, fixed programmable
// latency, range/alignment checking, flush for redirects and a load port
// for filling the array before execution.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   bus      : request/response handshake (slave side)
//   flush    : drop any outstanding request, block acceptance this cycle
//   ld_en    : write ld_data into mem[ld_addr] at the clock edge
//   ld_addr  : word index for the load port
//   ld_data  : word to write
module ifetch_sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ifetch_sram_responder_if.slave bus,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [32:0] SPAN     = 33'd4 << DEPTH_LOG2;
  // With a single-cycle latency the array is read at the accept edge and
  // the responder goes straight to RESP.
  localparam state_e      ISSUE_ST = (LATENCY == 1) ? ST_RESP : ST_WAIT;

  // Fault when misaligned, below the window, or beyond the last word.
  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'd0) | (a < BASE_ADDR) | ({1'b0, off} >= SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_r [0:(1 << DEPTH_LOG2) - 1];

  state_e                state_r, state_s;
  logic [3:0]            cnt_r, cnt_s;
  logic [31:0]           addr_r;
  logic                  err_r;
  logic                  rsp_valid_r;
  logic [31:0]           rsp_data_r;
  logic                  rsp_err_r;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  load_rsp_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic                  rd_err_s;

  assign req_ready_s = rst_n & ~flush &
                       ((state_r == ST_IDLE) | ((state_r == ST_RESP) & bus.rsp_ready));
  assign accept_s    = bus.req_valid & req_ready_s;

  // The array read is registered straight into rsp_data on entry to RESP.
  assign load_rsp_s = (LATENCY == 1) ? accept_s
                                     : ((state_r == ST_WAIT) & (cnt_r == 4'd1) & ~flush);
  assign rd_idx_s   = (LATENCY == 1) ? word_idx(bus.req_addr) : word_idx(addr_r);
  assign rd_err_s   = (LATENCY == 1) ? addr_err(bus.req_addr) : err_r;

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;

  // Next-state and latency-counter logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (flush) begin
      state_s = ST_IDLE;
      cnt_s   = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_s = ISSUE_ST;
            cnt_s   = CNT_INIT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_RESP: begin
          // Handshake and a new accept can share a cycle.
          if (accept_s) begin
            state_s = ISSUE_ST;
            cnt_s   = CNT_INIT;
          end else if (bus.rsp_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end
      endcase
    end
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= 32'd0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rsp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        addr_r <= bus.req_addr;
        err_r  <= addr_err(bus.req_addr);
      end
      if (load_rsp_s) begin
        rsp_err_r  <= rd_err_s;
        rsp_data_r <= rd_err_s ? 32'd0 : mem_r[rd_idx_s];
      end
    end
  end

  // Load port; not reset so contents survive rst_n. A same-edge read sees
  // the old word because both sides use non-blocking updates.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ifetch_sram_responder.sv
module tb_ifetch_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = 12'd0;
  logic [31:0] ld_data = 32'd0;

  always #5 clk = ~clk;

  ifetch_sram_responder_if b2 ();
  ifetch_sram_responder_if b1 ();

  assign b2.req_valid = req_valid;
  assign b2.req_addr  = req_addr;
  assign b2.rsp_ready = rsp_ready;
  assign b1.req_valid = req_valid;
  assign b1.req_addr  = req_addr;
  assign b1.rsp_ready = rsp_ready;

  ifetch_sram_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  ifetch_sram_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // index 0 = LATENCY 2 instance, index 1 = LATENCY 1 instance
  logic [1:0]  o_valid, o_ready, o_err;
  logic [31:0] o_data [2];
  assign o_valid   = {b1.rsp_valid, b2.rsp_valid};
  assign o_ready   = {b1.req_ready, b2.req_ready};
  assign o_err     = {b1.rsp_err, b2.rsp_err};
  assign o_data[0] = b2.rsp_data;
  assign o_data[1] = b1.rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one outstanding fetch per instance, its
  // accept cycle, and the word it will return.
  int          lat   [2] = '{2, 1};
  bit          busy  [2];
  int          acc   [2];
  logic [31:0] maddr [2];
  logic [31:0] edata [2];
  bit          eerr  [2];
  bit          dchk  [2];
  bit          vis_s [2];
  bit          rdy_s [2];
  logic [31:0] mmem  [4096];
  int          cyc = 0;

  function automatic bit model_err(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x % 4 != 0) || (x < 64'h8000_0000) || (x - 64'h8000_0000 >= 16384);
  endfunction

  function automatic int midx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) / 32'd4);
  endfunction

  // One clock cycle: apply inputs, check both instances, advance the model.
  task automatic drive(input bit rs, input bit v, input logic [31:0] a, input bit rr,
                       input bit fl, input bit le, input logic [11:0] la, input logic [31:0] ld);
    rst_n = rs; req_valid = v; req_addr = a; rsp_ready = rr;
    flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
    #1;
    for (int k = 0; k < 2; k++) begin
      vis_s[k] = busy[k] && (cyc >= acc[k] + lat[k]);
      rdy_s[k] = rs && !fl && (!busy[k] || (vis_s[k] && rr));
      check_eq($sformatf("L%0d.rsp_valid@%0d", lat[k], cyc), {31'd0, o_valid[k]}, {31'd0, vis_s[k]});
      check_eq($sformatf("L%0d.req_ready@%0d", lat[k], cyc), {31'd0, o_ready[k]}, {31'd0, rdy_s[k]});
      if (vis_s[k] || dchk[k]) begin
        check_eq($sformatf("L%0d.rsp_data@%0d", lat[k], cyc), o_data[k], edata[k]);
        check_eq($sformatf("L%0d.rsp_err@%0d", lat[k], cyc), {31'd0, o_err[k]}, {31'd0, eerr[k]});
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rs) begin
        busy[k] = 1'b0; edata[k] = 32'd0; eerr[k] = 1'b0; dchk[k] = 1'b1;
      end else begin
        dchk[k] = 1'b0;
        if (fl) begin
          busy[k] = 1'b0;
        end else begin
          if (vis_s[k] && rr) busy[k] = 1'b0;
          if (v && rdy_s[k]) begin
            busy[k] = 1'b1; acc[k] = cyc; maddr[k] = a;
          end
          if (busy[k] && cyc == acc[k] + lat[k] - 1) begin
            eerr[k]  = model_err(maddr[k]);
            edata[k] = eerr[k] ? 32'd0 : mmem[midx(maddr[k])];
          end
        end
      end
    end
    if (le) mmem[la] = ld;
    cyc++;
    @(negedge clk);
  endtask

  task automatic req(input bit v, input logic [31:0] a, input bit rr);
    drive(1'b1, v, a, rr, 1'b0, 1'b0, 12'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] w;
    r = $urandom_range(0, 13);
    w = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 32'd4;
    if (r < 10)       return w;
    else if (r == 10) return 32'h8000_3FFC;
    else if (r == 11) return w + 32'($urandom_range(1, 3));
    else if (r == 12) return 32'h8000_0000 - 32'($urandom_range(1, 64)) * 32'd4;
    else              return w + 32'h0000_4000;
  endfunction

  initial begin
    // Unchecked power-on reset so the registers are defined.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; acc[k] = 0; maddr[k] = 32'd0;
      edata[k] = 32'd0; eerr[k] = 1'b0; dchk[k] = 1'b1;
    end
    drive(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    check_eq("rst.rsp_valid", {31'd0, b2.rsp_valid}, 32'd0);
    check_eq("rst.rsp_data", b2.rsp_data, 32'd0);

    // Preload words 0..63 and the last word.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h0000_0413 : (i == 1) ? 32'h0010_0093 : (i == 3) ? 32'h1234_5678 : $urandom;
      drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 12'(i), w);
    end
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 12'd4095, 32'hCAFE_F00D);

    // Basic fetch and back-to-back request on the handshake cycle.
    req(1'b1, 32'h8000_0000, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("b2b.first", b2.rsp_data, 32'h0000_0413);
    req(1'b1, 32'h8000_0004, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("b2b.second", b2.rsp_data, 32'h0010_0093);
    req(1'b0, 32'd0, 1'b1);

    // Alignment and range boundaries.
    begin
      logic [31:0] ba [4];
      logic        be [4];
      ba = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_3FFC};
      be = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        req(1'b1, ba[i], 1'b1);
        req(1'b0, 32'd0, 1'b1);
        check_eq($sformatf("bound.err.%h", ba[i]), {31'd0, b2.rsp_err}, {31'd0, be[i]});
        check_eq($sformatf("bound.data.%h", ba[i]), b2.rsp_data, be[i] ? 32'd0 : 32'hCAFE_F00D);
        req(1'b0, 32'd0, 1'b1);
      end
    end

    // Back-pressure with a pending request.
    req(1'b1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 32'h8000_0004, 1'b0);
      if (i > 0) check_eq("bp.hold", b2.rsp_data, 32'h0000_0413);
    end
    req(1'b1, 32'h8000_0004, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("bp.next", b2.rsp_data, 32'h0010_0093);
    req(1'b0, 32'd0, 1'b1);

    // Flush while waiting.
    req(1'b1, 32'h8000_0000, 1'b1);
    drive(1'b1, 1'b1, 32'h8000_0004, 1'b1, 1'b1, 1'b0, 12'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 32'd0, 1'b1);
      check_eq("flush.novalid", {31'd0, b2.rsp_valid}, 32'd0);
    end
    req(1'b1, 32'h8000_0004, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("flush.after", b2.rsp_data, 32'h0010_0093);
    req(1'b0, 32'd0, 1'b1);

    // Load-port write colliding with the array read.
    req(1'b1, 32'h8000_000C, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 12'd3, 32'hDEAD_BEEF);
    check_eq("coll.old", b2.rsp_data, 32'h1234_5678);
    req(1'b1, 32'h8000_000C, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("coll.new", b2.rsp_data, 32'hDEAD_BEEF);
    req(1'b0, 32'd0, 1'b1);

    // Reset during RESP, then re-fetch.
    req(1'b1, 32'h8000_0000, 1'b0);
    req(1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    check_eq("rstresp.valid", {31'd0, b2.rsp_valid}, 32'd0);
    check_eq("rstresp.data", b2.rsp_data, 32'd0);
    check_eq("rstresp.err", {31'd0, b2.rsp_err}, 32'd0);
    req(1'b1, 32'h8000_0000, 1'b1);
    req(1'b0, 32'd0, 1'b1);
    check_eq("rstresp.refetch", b2.rsp_data, 32'h0000_0413);
    req(1'b0, 32'd0, 1'b1);

    // Single-cycle latency instance.
    req(1'b1, 32'h8000_0004, 1'b1);
    check_eq("lat1.valid", {31'd0, b1.rsp_valid}, 32'd1);
    check_eq("lat1.data", b1.rsp_data, 32'h0010_0093);
    req(1'b0, 32'd0, 1'b1);
    req(1'b0, 32'd0, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 60, rand_addr(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0, 12'($urandom_range(0, 63)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_sram_responder.md
# ifetch_sram_responder

Instruction-memory responder serving the fetch unit's 32-bit read requests over a valid/ready request/response handshake. It holds a word-addressed instruction SRAM, checks address range and alignment, and returns data after a programmable fixed latency. It accepts at most one request in flight and supports a flush for pipeline redirects. A load port fills the array before execution.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB)
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept request
- req_addr  in  32  byte address of instruction
- rsp_valid  out  1  response valid
- rsp_ready  in  1  fetch unit accepts response
- rsp_data  out  32  instruction word; 0 when rsp_err
- rsp_err  out  1  misaligned or out-of-range access
- flush  in  1  abort any outstanding request
- ld_en  in  1  array write enable
- ld_addr  in  DEPTH_LOG2  word index to write
- ld_data  in  32  word to write

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_addr and compute err = (addr[1:0]!=0) | (addr<BASE_ADDR) | (addr-BASE_ADDR >= 4<<DEPTH_LOG2). Load the counter with LATENCY-1. Go to RESP if LATENCY==1, else go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter is 1, read the array at index (addr-BASE_ADDR)>>2 (32-bit subtract, low DEPTH_LOG2 bits after shift), then go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err stay stable until rsp_ready.
  - On rsp_ready, return to IDLE.
  - req_ready = rsp_ready in RESP, so a new request is accepted in the same cycle as the response handshake and goes directly to WAIT or RESP per LATENCY.
- Array read is synchronous. The data word is registered into rsp_data on entry to RESP. When err=1, rsp_data is forced to 0 and the array value is ignored.
- Load port: ld_en writes ld_data to mem[ld_addr] at the clock edge, in any state.
  - A write and a read to the same word in the same cycle: the read returns the old value.
- flush:
  - Highest priority: in any state, the next state is IDLE and rsp_valid=0 the following cycle.
  - A request presented in a flush cycle is not accepted; req_ready=0 while flush=1.
  - A response completing a handshake in the same cycle as flush counts as delivered.
- Reset (rst_n=0 at edge): state IDLE, counter 0, rsp_valid 0, rsp_data 0, rsp_err 0, latched address 0. Memory contents are not reset.
  - req_ready is 0 while rst_n=0 and 1 the first cycle after release.
  - Reset mid-WAIT or mid-RESP drops the request with no response.

## Timing
- Accept at edge N gives rsp_valid high from edge N+LATENCY.
- Throughput with rsp_ready held 1 is one response per LATENCY cycles.
- Back-pressure: rsp_valid stays high and outputs are frozen for as many cycles as rsp_ready=0. No new request is accepted during that time.
- All outputs are registered, except req_ready, which is combinational from state, rsp_ready, flush and rst_n.
- No combinational path from req_* to rsp_*.

## Test plan
- Preload mem[0]=32'h0000_0413, mem[1]=32'h0010_0093. LATENCY=2: request 0x8000_0000 accepted at cycle 10 -> rsp_valid at cycle 12, rsp_data=0x0000_0413, rsp_err=0. Back-to-back request 0x8000_0004 at cycle 12 -> data 0x0010_0093 at cycle 14.
- Request 0x8000_0002 -> rsp_err=1, rsp_data=0. Request 0x7FFF_FFFC and 0x8000_4000 (DEPTH_LOG2=12) -> rsp_err=1 for both. Request 0x8000_3FFC -> last word, err=0.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0 throughout. Release -> handshake; a pending request is accepted that same cycle.
- flush in WAIT -> next cycle IDLE, no response ever appears. A new request afterwards returns correct data after LATENCY cycles.
- ld_en writing mem[3]=0xDEAD_BEEF in the same cycle the array read of word 3 occurs -> response carries the old value. A repeat request returns 0xDEAD_BEEF.
- rst_n=0 for 1 cycle during RESP -> rsp_valid=0, rsp_data=0, rsp_err=0 next cycle. Memory contents are preserved: a re-request of 0x8000_0000 returns 0x0000_0413. Repeat the scenario with LATENCY=1: accept at N gives response at N+1.
